vec_sumsq_engine: RTL and testbench
===================================

Name: vec_sumsq_engine

Overview:
- Streaming sum-of-squares engine for the vector machine datapath; parametrised successor to the fixed two-operand square/accumulate datapath.
- Accepts LANES signed elements per beat over a valid/ready stream for a programmed vector length, squares every lane, reduces across lanes and accumulates. Returns one result per vector on an output valid/ready handshake.
- Integrated control FSM, so no external store/square/sum enables are needed.

Parameters:
- DATA_W, 24, width of each signed input element.
- LANES, 2, elements per input beat (>=1).
- LEN_W, 8, width of vector length; max vector length is 2^LEN_W-1 beats.
- RES_W, 48, width of the result port (<= ACC_W).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begins a vector; sampled only in IDLE.
- vec_len  input  LEN_W  beats in the vector; captured with start.
- in_valid  input  1  input beat valid.
- in_ready  output  1  engine accepts a beat.
- in_data  input  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W], two's complement.
- busy  output  1  high whenever state != IDLE.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  RES_W  sum of squares.
- overflow  output  1  accumulated value exceeded RES_W (SUMSQ_SAT_EN only).

Behaviour:
- Widths:
  - SQ_W = 2*DATA_W, unsigned square.
  - TREE_W = SQ_W + clog2(LANES).
  - ACC_W = TREE_W + LEN_W.
  - The internal accumulator never overflows.
- Reset (rst low, asynchronous): state IDLE; in_ready, out_valid, busy, overflow = 0; result, accumulator, beat counter and pipeline valids = 0.
- FSM states:
  - IDLE: start=1 captures vec_len and clears the accumulator. Go to RUN if vec_len != 0, else go to DONE with result 0.
  - RUN: in_ready = 1 while accepted < vec_len. A beat transfers on in_valid && in_ready. After the last transfer, go to DRAIN.
  - DRAIN: wait until pipeline valids are empty and the final accumulate is done, then go to DONE.
  - DONE: out_valid = 1, result held stable. On out_ready, go to IDLE next cycle.
- Pipeline (per-stage valid bit; no stall required because downstream always accepts):
  - S1: register in_data.
  - S2: register per-lane squares.
  - S3: adder tree plus accumulate.
- Latency: out_valid rises exactly 4 cycles after the clock edge that accepts the last beat. The vec_len=0 case gives out_valid 1 cycle after start.
- in_valid gaps (bubbles) are permitted at any beat and do not change the result.
- start while busy: ignored.
- start in the same cycle as the out_ready handshake: ignored; a new start is needed in IDLE.
- in_valid outside RUN: ignored, in_ready = 0.
- Without SUMSQ_SAT_EN:
  - result = acc[RES_W-1:0] (wraps).
  - overflow tied 0.
- Reset mid-operation: abandons the vector immediately; no partial result is emitted.

Optional Feature:
- Macro SUMSQ_SAT_EN.
- Defined: if acc >= 2^RES_W, result = 2^RES_W-1 and overflow = 1. overflow is valid with out_valid and cleared on the next start.
- Undefined: truncating wrap as above; overflow constant 0; saturation comparator not built.

Decomposition:
- Package sumsq_pkg holds:
  - FSM state enum: IDLE, RUN, DRAIN, DONE.
  - Width helper functions: clog2, SQ_W, TREE_W, ACC_W.
- Sub-module sumsq_lane_square: one signed DATA_W input producing a registered unsigned SQ_W square with valid pass-through. Instantiate LANES times in a generate loop.
- Adder tree and FSM stay in the top module.

Test Plan (DATA_W=24, LANES=2, LEN_W=8, RES_W=48):
- Basic: vec_len=2, beats (3,4),(1,-2), continuous valid -> result=30, out_valid 4 cycles after beat 2, overflow=0.
- Bubbles/backpressure: same vector with 3 idle cycles between beats and out_ready held low for 5 cycles -> result 30 held stable and out_valid held until out_ready.
- Zero length: start with vec_len=0 -> out_valid the next cycle, result=0, in_ready never asserted.
- Extreme: vec_len=255, every lane = -2^23 -> acc = 255*2^47. With SUMSQ_SAT_EN: result = 2^48-1, overflow=1. Without it: result = acc mod 2^48 = 2^47, overflow=0.
- Reset mid-run: assert rst low after beat 1 of a 4-beat vector -> all outputs 0 asynchronously. After release, a fresh start with vec_len=1, beat (5,12) -> result=169.
- Ignored start: pulse start during RUN with vec_len=7 -> the original vec_len=3 vector completes unchanged, and exactly one result is emitted.

Source files
------------

// File: rtl/sumsq_pkg.sv
// Shared types and width helpers for the vec_sumsq_engine slice.
package sumsq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

    function automatic int sq_w(input int data_w);
        return 2 * data_w;
    endfunction

    // One extra bit per doubling of lanes keeps the cross-lane sum exact.
    function automatic int tree_w(input int data_w, input int lanes);
        return sq_w(data_w) + clog2(lanes);
    endfunction

    function automatic int acc_w(input int data_w, input int lanes, input int len_w);
        return tree_w(data_w, lanes) + len_w;
    endfunction

endpackage

// File: rtl/sumsq_lane_square.sv
// One lane of the squaring stage: registered unsigned square of a signed
// element, with its valid bit carried alongside.
module sumsq_lane_square
    import sumsq_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vld,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  o_vld,
    output logic [2*DATA_W-1:0]   o_sq
);

    localparam int SQ_W = sq_w(DATA_W);

    logic signed [DATA_W-1:0] w_data;
    logic signed [SQ_W-1:0]   w_prod;
    logic [SQ_W-1:0]          r_sq;
    logic                     r_vld;

    assign w_data = signed'(i_data);
    // Even -2^(DATA_W-1) squared is 2^(SQ_W-2), so the signed product never wraps.
    assign w_prod = w_data * w_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= 1'b0;
        end else begin
            r_vld <= i_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (i_vld) begin
            r_sq <= unsigned'(w_prod);
        end
    end

    assign o_vld = r_vld;
    assign o_sq  = r_sq;

endmodule

// File: rtl/vec_sumsq_engine.sv
// Streaming sum-of-squares engine: LANES elements per beat, one result per vector.
// Define SUMSQ_SAT_EN to saturate the result and report overflow.
module vec_sumsq_engine
    import sumsq_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int LANES  = 2,
    parameter int LEN_W  = 8,
    parameter int RES_W  = 48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LEN_W-1:0]          vec_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RES_W-1:0]          result,
    output logic                      overflow
);

    localparam int SQ_W   = sq_w(DATA_W);
    localparam int TREE_W = tree_w(DATA_W, LANES);
    localparam int ACC_W  = acc_w(DATA_W, LANES, LEN_W);

    state_t                    r_state;
    state_t                    w_next;
    logic [LEN_W-1:0]          r_len;
    logic [LEN_W-1:0]          r_cnt;
    logic                      w_xfer;
    logic                      w_clr;
    logic                      w_zero;
    logic                      w_load;

    logic [LANES*DATA_W-1:0]   r_data_p0;
    logic                      r_vld_p0;
    logic [SQ_W-1:0]           w_sq_p1 [LANES];
    logic [LANES-1:0]          w_vld_p1;
    logic                      w_stage_vld_p1;
    logic [TREE_W-1:0]         w_tree_p1;
    logic [ACC_W-1:0]          r_acc;
    logic                      r_vld_p2;
    logic [RES_W-1:0]          r_result;
    logic [RES_W-1:0]          w_res;

    assign w_xfer = in_valid && in_ready;

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        w_clr    = 1'b0;
        w_zero   = 1'b0;
        w_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clr = 1'b1;
                    if (vec_len == '0) begin
                        w_zero = 1'b1;
                        w_next = DONE;
                    end else begin
                        w_next = RUN;
                    end
                end
            end
            RUN: begin
                in_ready = (r_cnt < r_len);
                if (in_valid && in_ready && (r_cnt == r_len - LEN_W'(1))) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                // The last beat has left every stage once all valids are low.
                if (!(r_vld_p0 || w_stage_vld_p1 || r_vld_p2)) begin
                    w_load = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_clr) begin
                r_len <= vec_len;
                r_cnt <= '0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

    // ---- stage p0: capture accepted beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= w_xfer;
        end
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_data_p0 <= in_data;
        end
    end

    // ---- stage p1: per-lane squares
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sumsq_lane_square #(
            .DATA_W (DATA_W)
        ) u_sq (
            .clk    (clk),
            .rst    (rst),
            .i_vld  (r_vld_p0),
            .i_data (r_data_p0[k*DATA_W +: DATA_W]),
            .o_vld  (w_vld_p1[k]),
            .o_sq   (w_sq_p1[k])
        );
    end

    assign w_stage_vld_p1 = |w_vld_p1;

    always_comb begin
        w_tree_p1 = '0;
        for (int k = 0; k < LANES; k++) begin
            w_tree_p1 = w_tree_p1 + TREE_W'(w_sq_p1[k]);
        end
    end

    // ---- stage p2: cross-lane sum into the accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= w_stage_vld_p1;
            if (w_clr) begin
                r_acc <= '0;
            end else if (w_stage_vld_p1) begin
                r_acc <= r_acc + ACC_W'(w_tree_p1);
            end
        end
    end

`ifdef SUMSQ_SAT_EN
    logic w_ovf;
    logic r_ovf;

    function automatic logic [RES_W-1:0] sat_res(input logic [ACC_W-1:0] acc, input logic ovf);
        return ovf ? {RES_W{1'b1}} : acc[RES_W-1:0];
    endfunction

    assign w_ovf = ((r_acc >> RES_W) != '0);
    assign w_res = sat_res(r_acc, w_ovf);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_clr) begin
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`else
    logic w_unused_acc_hi;

    assign w_res           = r_acc[RES_W-1:0];
    assign w_unused_acc_hi = ^(r_acc >> RES_W);
    assign overflow        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
        end else if (w_zero) begin
            r_result <= '0;
        end else if (w_load) begin
            r_result <= w_res;
        end
    end

    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

endmodule

// File: tb/tb_vec_sumsq_engine.sv
// Directed bench for vec_sumsq_engine (DATA_W=24, LANES=2, LEN_W=8, RES_W=48).
module tb_vec_sumsq_engine;

    localparam int DATA_W = 24;
    localparam int LANES  = 2;
    localparam int LEN_W  = 8;
    localparam int RES_W  = 48;

`ifdef SUMSQ_SAT_EN
    localparam logic [63:0] EXP_EXT_RES = 64'h0000_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_EXT_OVF = 64'd1;
`else
    localparam logic [63:0] EXP_EXT_RES = 64'h0000_8000_0000_0000;
    localparam logic [63:0] EXP_EXT_OVF = 64'd0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [LEN_W-1:0]        vec_len;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [RES_W-1:0]        result;
    logic                    overflow;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    vec_sumsq_engine #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .LEN_W  (LEN_W),
        .RES_W  (RES_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*DATA_W-1:0] beat(input int lane0, input int lane1);
        return {DATA_W'(lane1), DATA_W'(lane0)};
    endfunction

    task automatic wait_out(input string tag, input int budget);
        int k;
        k = 0;
        while (!out_valid && k < budget) begin
            tick;
            k++;
        end
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        vec_len   = '0;
        in_valid  = 1'b1;
        in_data   = beat(7, 7);
        out_ready = 1'b0;

        #12;
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        rst = 1'b1;
        tick;
        chk("idle_in_valid_ignored", 64'(in_ready), 64'd0);
        chk("idle_busy",             64'(busy),     64'd0);
        in_valid = 1'b0;

        // Basic: (3,4),(1,-2) -> 25 + 5 = 30, latency 4 edges after last beat
        start = 1'b1; vec_len = 8'd2;
        tick;
        start = 1'b0;
        chk("basic_busy",     64'(busy),     64'd1);
        chk("basic_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_data = beat(3, 4);
        tick;
        in_data = beat(1, -2);
        tick;
        in_valid = 1'b0;
        chk("basic_ready_drop", 64'(in_ready), 64'd0);
        tick; tick; tick;
        chk("basic_lat_early", 64'(out_valid), 64'd0);
        tick;
        chk("basic_lat",      64'(out_valid), 64'd1);
        chk("basic_result",   64'(result),    64'd30);
        chk("basic_overflow", 64'(overflow),  64'd0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("basic_ack_ov",   64'(out_valid), 64'd0);
        chk("basic_ack_busy", 64'(busy),      64'd0);

        // Bubbles and held output
        start = 1'b1; vec_len = 8'd2;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_data = beat(3, 4);
        tick;
        in_valid = 1'b0; in_data = beat(9, 9);
        repeat (3) tick;
        chk("bub_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_data = beat(1, -2);
        tick;
        in_valid = 1'b0;
        wait_out("bub_out_valid", 10);
        for (int i = 0; i < 5; i++) begin
            chk("bub_hold_result", 64'(result),    64'd30);
            chk("bub_hold_valid",  64'(out_valid), 64'd1);
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("bub_release", 64'(out_valid), 64'd0);

        // Zero length
        start = 1'b1; vec_len = 8'd0;
        tick;
        start = 1'b0;
        chk("zero_out_valid", 64'(out_valid), 64'd1);
        chk("zero_result",    64'(result),    64'd0);
        chk("zero_in_ready",  64'(in_ready),  64'd0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("zero_idle", 64'(busy), 64'd0);

        // Extreme: 255 beats of (-2^23,-2^23) -> acc = 255 * 2^47
        start = 1'b1; vec_len = 8'd255;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_data = beat(-(1 << 23), -(1 << 23));
        repeat (255) tick;
        in_valid = 1'b0;
        chk("ext_ready_drop", 64'(in_ready), 64'd0);
        wait_out("ext_out_valid", 10);
        chk("ext_result",   64'(result),   EXP_EXT_RES);
        chk("ext_overflow", 64'(overflow), EXP_EXT_OVF);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // Reset mid-run, then a fresh one-beat vector (5,12) -> 169
        start = 1'b1; vec_len = 8'd4;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_data = beat(5, 5);
        tick;
        in_valid = 1'b0;
        chk("rr_busy_before", 64'(busy), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("rr_busy",      64'(busy),      64'd0);
        chk("rr_in_ready",  64'(in_ready),  64'd0);
        chk("rr_out_valid", 64'(out_valid), 64'd0);
        chk("rr_result",    64'(result),    64'd0);
        chk("rr_overflow",  64'(overflow),  64'd0);
        tick;
        rst = 1'b1;
        tick;
        chk("rr_idle_after", 64'(busy), 64'd0);
        start = 1'b1; vec_len = 8'd1;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_data = beat(5, 12);
        tick;
        in_valid = 1'b0;
        wait_out("rr_out_valid_fresh", 10);
        chk("rr_result_fresh", 64'(result), 64'd169);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // Start while busy ignored: (1,1),(2,2),(3,3) -> 2 + 8 + 18 = 28
        start = 1'b1; vec_len = 8'd3;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_data = beat(1, 1);
        tick;
        start = 1'b1; vec_len = 8'd7; in_data = beat(2, 2);
        tick;
        start = 1'b0; in_data = beat(3, 3);
        tick;
        in_valid = 1'b0;
        chk("ign_ready_drop", 64'(in_ready), 64'd0);
        wait_out("ign_out_valid", 10);
        chk("ign_result", 64'(result), 64'd28);
        // start coinciding with the result handshake must not launch a vector
        start = 1'b1; vec_len = 8'd1; out_ready = 1'b1;
        tick;
        start = 1'b0; out_ready = 1'b0;
        chk("ign_hs_busy",  64'(busy),      64'd0);
        chk("ign_hs_valid", 64'(out_valid), 64'd0);
        repeat (8) tick;
        chk("ign_single_result", 64'(out_valid), 64'd0);
        chk("ign_stay_idle",     64'(busy),      64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
